idma_tl_channel_scheduler: RTL and testbench

Shares one iDMA transport layer (OBI-read/AXI-write or any read/write protocol pair) between NumChannels independent backend channels. Grants one burst per cycle max, round-robin, and forks it into the four transport inputs (read meta, write meta, read dp req, write dp req). Tracks per-burst channel IDs in order and routes in-order read/write datapath responses back to the owning channel. Sits between channel legalizers and the transport layer.

---
 rtl/idma_tl_sched_pkg.sv | 25 ++
 rtl/idma_tl_fork.sv | 24 ++
 rtl/idma_tl_channel_scheduler.sv | 159 +++++++++++++++
 tb/tb_idma_tl_channel_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/idma_tl_sched_pkg.sv
// idma_tl_sched_pkg: shared types, FSM states and width helpers for the TL channel scheduler.
package idma_tl_sched_pkg;

    typedef logic [15:0] dflt_ar_t;
    typedef logic [15:0] dflt_aw_t;
    typedef logic [7:0]  dflt_r_req_t;
    typedef logic [7:0]  dflt_w_req_t;
    typedef logic [31:0] dflt_r_rsp_t;
    typedef logic [31:0] dflt_w_rsp_t;

    typedef struct packed {
        dflt_ar_t    ar;
        dflt_aw_t    aw;
        dflt_r_req_t r;
        dflt_w_req_t w;
    } dflt_burst_t;

    typedef enum logic {S_IDLE, S_ISSUE} sched_state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/idma_tl_fork.sv
// idma_tl_fork: forks one held burst into four independent valid/ready handshakes,
// remembering which legs already completed.
module idma_tl_fork (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_valid,
    input  logic [3:0] i_ready,
    output logic [3:0] o_valid,
    output logic       o_done
);

    logic [3:0] r_sent;
    logic [3:0] w_fire;

    assign o_valid = {4{i_valid}} & ~r_sent;
    assign w_fire  = o_valid & i_ready;
    assign o_done  = i_valid & (&(r_sent | w_fire));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_sent <= '0;
        else       r_sent <= o_done ? '0 : (r_sent | w_fire);
    end

endmodule

// File: rtl/idma_tl_channel_scheduler.sv
// idma_tl_channel_scheduler: round-robin shares one iDMA transport layer between channels
// and routes in-order datapath responses back to the channel that issued each burst.
module idma_tl_channel_scheduler
    import idma_tl_sched_pkg::*;
#(
    parameter int unsigned NumChannels          = 2,
    parameter int unsigned NumAxInFlight        = 2,
    parameter type         read_meta_channel_t  = dflt_ar_t,
    parameter type         write_meta_channel_t = dflt_aw_t,
    parameter type         r_dp_req_t           = dflt_r_req_t,
    parameter type         w_dp_req_t           = dflt_w_req_t,
    parameter type         r_dp_rsp_t           = dflt_r_rsp_t,
    parameter type         w_dp_rsp_t           = dflt_w_rsp_t,
    parameter type         burst_t              = dflt_burst_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumChannels-1:0]   ch_valid_i,
    output logic [NumChannels-1:0]   ch_ready_o,
    input  burst_t                   ch_burst_i [NumChannels],
    output r_dp_rsp_t                ch_r_rsp_o,
    output w_dp_rsp_t                ch_w_rsp_o,
    output logic [NumChannels-1:0]   ch_r_valid_o,
    output logic [NumChannels-1:0]   ch_w_valid_o,
    input  logic [NumChannels-1:0]   ch_r_ready_i,
    input  logic [NumChannels-1:0]   ch_w_ready_i,
    output read_meta_channel_t       ar_req_o,
    output logic                     ar_valid_o,
    input  logic                     ar_ready_i,
    output write_meta_channel_t      aw_req_o,
    output logic                     aw_valid_o,
    input  logic                     aw_ready_i,
    output r_dp_req_t                r_dp_req_o,
    output logic                     r_dp_valid_o,
    input  logic                     r_dp_ready_i,
    output w_dp_req_t                w_dp_req_o,
    output logic                     w_dp_valid_o,
    input  logic                     w_dp_ready_i,
    input  r_dp_rsp_t                r_dp_rsp_i,
    input  logic                     r_dp_valid_i,
    output logic                     r_dp_ready_o,
    input  w_dp_rsp_t                w_dp_rsp_i,
    input  logic                     w_dp_valid_i,
    output logic                     w_dp_ready_o,
    output logic                     busy_o
);

    localparam int unsigned IdW  = idx_w(NumChannels);
    localparam int unsigned PtrW = idx_w(NumAxInFlight);
    localparam int unsigned CntW = $clog2(NumAxInFlight + 1);

    typedef logic [IdW-1:0] ch_id_t;

    sched_state_e    r_state, w_state_nxt;
    ch_id_t          r_ptr, w_win, w_idx;
    logic            w_found, w_grant, w_done;
    logic [CntW-1:0] r_cnt;
    burst_t          r_burst;
    logic [3:0]      w_fork_valid;
    logic [1:0]      w_pop, w_empty;
    ch_id_t          w_head [2];

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NumChannels; i++) begin
            w_idx = ch_id_t'((32'(r_ptr) + i) % NumChannels);
            if (!w_found && ch_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Grant is gated by reset so no ready leaks out while the block is held in reset.
    assign w_grant    = !rst_i && (r_state == S_IDLE) && (r_cnt < CntW'(NumAxInFlight)) && w_found;
    assign ch_ready_o = w_grant ? (NumChannels'(1) << w_win) : '0;

    always_comb begin
        w_state_nxt = (r_state == S_IDLE) ? (w_grant ? S_ISSUE : S_IDLE) : (w_done ? S_IDLE : S_ISSUE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_ptr <= (32'(w_win) == NumChannels - 1) ? '0 : w_win + 1'b1;
            r_cnt <= r_cnt + CntW'(w_grant) - CntW'(w_pop[1]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_grant) r_burst <= ch_burst_i[w_win];
    end

    idma_tl_fork i_fork (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (r_state == S_ISSUE),
        .i_ready ({w_dp_ready_i, r_dp_ready_i, aw_ready_i, ar_ready_i}),
        .o_valid (w_fork_valid),
        .o_done  (w_done)
    );

    assign {w_dp_valid_o, r_dp_valid_o, aw_valid_o, ar_valid_o} = w_fork_valid;
    assign ar_req_o   = r_burst.ar;
    assign aw_req_o   = r_burst.aw;
    assign r_dp_req_o = r_burst.r;
    assign w_dp_req_o = r_burst.w;

    // Index 0 tracks read-response ownership, index 1 write-response ownership.
    assign w_pop = {w_dp_valid_i & w_dp_ready_o, r_dp_valid_i & r_dp_ready_o};

    for (genvar f = 0; f < 2; f++) begin : g_idq
        ch_id_t          r_mem [NumAxInFlight];
        logic [PtrW-1:0] r_wp, r_rp;
        logic [CntW-1:0] r_n;
        always_ff @(posedge clk_i) begin
            if (w_grant) r_mem[r_wp] <= w_win;
        end
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_wp <= '0;
                r_rp <= '0;
                r_n  <= '0;
            end else begin
                if (w_grant)  r_wp <= (r_wp == PtrW'(NumAxInFlight - 1)) ? '0 : r_wp + 1'b1;
                if (w_pop[f]) r_rp <= (r_rp == PtrW'(NumAxInFlight - 1)) ? '0 : r_rp + 1'b1;
                r_n <= r_n + CntW'(w_grant) - CntW'(w_pop[f]);
            end
        end
        assign w_empty[f] = (r_n == '0);
        assign w_head[f]  = r_mem[r_rp];
        always_ff @(posedge clk_i) begin
            if (!rst_i) assert (!(w_grant && !w_pop[f] && r_n == CntW'(NumAxInFlight)));
        end
    end

    assign r_dp_ready_o = !w_empty[0] && ch_r_ready_i[w_head[0]];
    assign w_dp_ready_o = !w_empty[1] && ch_w_ready_i[w_head[1]];
    assign ch_r_valid_o = (r_dp_valid_i && !w_empty[0]) ? (NumChannels'(1) << w_head[0]) : '0;
    assign ch_w_valid_o = (w_dp_valid_i && !w_empty[1]) ? (NumChannels'(1) << w_head[1]) : '0;
    assign ch_r_rsp_o   = r_dp_rsp_i;
    assign ch_w_rsp_o   = w_dp_rsp_i;
    assign busy_o       = (r_state != S_IDLE) || (r_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(r_dp_valid_i && w_empty[0]));
            assert (!(w_dp_valid_i && w_empty[1]));
            assert (r_cnt <= CntW'(NumAxInFlight));
        end
    end

endmodule

// File: tb/tb_idma_tl_channel_scheduler.sv
// tb_idma_tl_channel_scheduler: directed stimulus checked every cycle against a queue-based
// behavioural model of grant order, fork progress and response ownership.
module tb_idma_tl_channel_scheduler;
    import idma_tl_sched_pkg::*;

    localparam int NC  = 2;
    localparam int NAX = 2;

    logic          clk, rst_i;
    logic [NC-1:0] ch_valid_i, ch_ready_o, ch_r_valid_o, ch_w_valid_o, ch_r_ready_i, ch_w_ready_i;
    dflt_burst_t   ch_burst_i [NC];
    dflt_r_rsp_t   ch_r_rsp_o, r_dp_rsp_i;
    dflt_w_rsp_t   ch_w_rsp_o, w_dp_rsp_i;
    dflt_ar_t      ar_req_o;
    dflt_aw_t      aw_req_o;
    dflt_r_req_t   r_dp_req_o;
    dflt_w_req_t   w_dp_req_o;
    logic ar_valid_o, ar_ready_i, aw_valid_o, aw_ready_i, r_dp_valid_o, r_dp_ready_i;
    logic w_dp_valid_o, w_dp_ready_i, r_dp_valid_i, r_dp_ready_o, w_dp_valid_i, w_dp_ready_o, busy_o;

    idma_tl_channel_scheduler #(.NumChannels(NC), .NumAxInFlight(NAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o), .ch_burst_i(ch_burst_i),
        .ch_r_rsp_o(ch_r_rsp_o), .ch_w_rsp_o(ch_w_rsp_o),
        .ch_r_valid_o(ch_r_valid_o), .ch_w_valid_o(ch_w_valid_o),
        .ch_r_ready_i(ch_r_ready_i), .ch_w_ready_i(ch_w_ready_i),
        .ar_req_o(ar_req_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .aw_req_o(aw_req_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .r_dp_req_o(r_dp_req_o), .r_dp_valid_o(r_dp_valid_o), .r_dp_ready_i(r_dp_ready_i),
        .w_dp_req_o(w_dp_req_o), .w_dp_valid_o(w_dp_valid_o), .w_dp_ready_i(w_dp_ready_i),
        .r_dp_rsp_i(r_dp_rsp_i), .r_dp_valid_i(r_dp_valid_i), .r_dp_ready_o(r_dp_ready_o),
        .w_dp_rsp_i(w_dp_rsp_i), .w_dp_valid_i(w_dp_valid_i), .w_dp_ready_o(w_dp_ready_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0, nfail = 0, seq = 0;
    bit auto_r = 0, auto_w = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: held burst with per-leg sent flags, owner queues in grant order, in-flight count.
    bit          m_hold;
    bit   [3:0]  m_sent;
    dflt_burst_t m_b;
    int          m_ptr, m_infl, win;
    int          rq[$], wq[$];
    logic [3:0]  e_v, rdy;
    logic [NC-1:0] e_ready, e_rv, e_wv;
    logic        e_rr, e_wr;

    always @(negedge clk) begin
        if (rst_i) begin
            chk("reset_outs", {ch_ready_o, ar_valid_o, aw_valid_o, r_dp_valid_o, w_dp_valid_o,
                               r_dp_ready_o, w_dp_ready_o, busy_o}, '0);
            m_hold = 0; m_sent = '0; m_ptr = 0; m_infl = 0;
            rq.delete(); wq.delete();
        end else begin
            win = -1;
            if (!m_hold && m_infl < NAX)
                for (int i = 0; i < NC; i++)
                    if (win < 0 && ch_valid_i[(m_ptr + i) % NC]) win = (m_ptr + i) % NC;
            e_ready = (win >= 0) ? NC'(1) << win : '0;
            e_v  = m_hold ? ~m_sent : 4'b0;
            rdy  = {w_dp_ready_i, r_dp_ready_i, aw_ready_i, ar_ready_i};
            e_rr = rq.size() > 0 && ch_r_ready_i[rq[0]];
            e_wr = wq.size() > 0 && ch_w_ready_i[wq[0]];
            e_rv = (rq.size() > 0 && r_dp_valid_i) ? NC'(1) << rq[0] : '0;
            e_wv = (wq.size() > 0 && w_dp_valid_i) ? NC'(1) << wq[0] : '0;
            chk("ch_ready", ch_ready_o, e_ready);
            chk("tl_valids", {w_dp_valid_o, r_dp_valid_o, aw_valid_o, ar_valid_o}, e_v);
            if (e_v[0]) chk("ar_req", ar_req_o, m_b.ar);
            if (e_v[1]) chk("aw_req", aw_req_o, m_b.aw);
            if (e_v[2]) chk("r_dp_req", r_dp_req_o, m_b.r);
            if (e_v[3]) chk("w_dp_req", w_dp_req_o, m_b.w);
            chk("r_dp_ready", r_dp_ready_o, e_rr);
            chk("w_dp_ready", w_dp_ready_o, e_wr);
            chk("ch_r_valid", ch_r_valid_o, e_rv);
            chk("ch_w_valid", ch_w_valid_o, e_wv);
            chk("ch_r_rsp", ch_r_rsp_o, r_dp_rsp_i);
            chk("ch_w_rsp", ch_w_rsp_o, w_dp_rsp_i);
            chk("busy", busy_o, m_hold || m_infl != 0);
            if (r_dp_valid_i && e_rr) void'(rq.pop_front());
            if (w_dp_valid_i && e_wr) begin void'(wq.pop_front()); m_infl--; end
            if (m_hold) begin
                m_sent |= e_v & rdy;
                if (&m_sent) begin m_hold = 0; m_sent = '0; end
            end
            if (win >= 0) begin
                m_hold = 1; m_b = ch_burst_i[win];
                rq.push_back(win); wq.push_back(win);
                m_infl++; m_ptr = (win + 1) % NC;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        seq++;
        for (int c = 0; c < NC; c++) begin
            ch_burst_i[c].ar = 16'(seq * 4 + c);
            ch_burst_i[c].aw = 16'(16'h8000 + seq * 4 + c);
            ch_burst_i[c].r  = 8'(seq + c * 64);
            ch_burst_i[c].w  = 8'(seq * 3 + c);
        end
        r_dp_rsp_i   = 32'(seq * 7);
        w_dp_rsp_i   = 32'(seq * 11 + 1);
        r_dp_valid_i = auto_r && rq.size() != 0;
        w_dp_valid_i = auto_w && wq.size() != 0;
    endtask

    task automatic drain();
        auto_r = 1; auto_w = 1; ch_valid_i = '0;
        for (int i = 0; i < 40 && (m_hold || rq.size() != 0 || wq.size() != 0); i++) step();
        @(negedge clk); chk("drain_idle", busy_o, 1'b0);
        step();
    endtask

    logic [NC-1:0] gseq[$];
    int na, nr, ng;

    initial begin
        #200000 $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1; ch_valid_i = '0; ch_r_ready_i = '1; ch_w_ready_i = '1;
        ar_ready_i = 1; aw_ready_i = 1; r_dp_ready_i = 1; w_dp_ready_i = 1;
        r_dp_valid_i = 0; w_dp_valid_i = 0; r_dp_rsp_i = '0; w_dp_rsp_i = '0;
        for (int c = 0; c < NC; c++) ch_burst_i[c] = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        // single burst on ch0
        ch_valid_i = 2'b01;
        @(negedge clk); chk("t1_grant", ch_ready_o, 2'b01);
        step(); ch_valid_i = '0;
        @(negedge clk); chk("t1_issue", {w_dp_valid_o, r_dp_valid_o, aw_valid_o, ar_valid_o}, 4'hf);
        step();
        @(negedge clk); chk("t1_once", {w_dp_valid_o, r_dp_valid_o, aw_valid_o, ar_valid_o}, 4'h0);
        chk("t1_busy", busy_o, 1'b1);
        step(); r_dp_valid_i = 1;
        @(negedge clk); chk("t1_rroute", ch_r_valid_o, 2'b01);
        step(); w_dp_valid_i = 1;
        @(negedge clk); chk("t1_wroute", ch_w_valid_o, 2'b01);
        step();
        @(negedge clk); chk("t1_idle", busy_o, 1'b0);
        // both channels continuously requesting: pointer sits at 1 after the ch0 grant
        auto_r = 1; auto_w = 1;
        step(); ch_valid_i = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); if (ch_ready_o != '0) gseq.push_back(ch_ready_o);
            step();
        end
        chk("t2_ngrants", gseq.size(), 6);
        if (gseq.size() >= 4) begin
            chk("t2_g0", gseq[0], 2'b10); chk("t2_g1", gseq[1], 2'b01);
            chk("t2_g2", gseq[2], 2'b10); chk("t2_g3", gseq[3], 2'b01);
        end
        drain();
        // aw stalled five cycles
        ch_valid_i = 2'b01; aw_ready_i = 0;
        step(); ch_valid_i = 2'b10; na = 0; nr = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin aw_ready_i = 1; ch_valid_i = '0; end
            @(negedge clk);
            na += int'(aw_valid_o); nr += int'(ar_valid_o);
            if (i < 5) chk("t3_nogrant", ch_ready_o, '0);
            step();
        end
        chk("t3_aw_cycles", na, 6);
        chk("t3_ar_cycles", nr, 1);
        drain();
        // in-flight limit with no write responses
        auto_r = 0; auto_w = 0; ch_valid_i = 2'b01; ng = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); if (ch_ready_o != '0) ng++;
            step();
        end
        chk("t4_limit", ng, 2);
        auto_r = 1; step(); step(); step(); auto_r = 0;
        w_dp_valid_i = 1;
        @(negedge clk); chk("t4_blocked_at_wpop", ch_ready_o, 2'b00);
        step();
        @(negedge clk); chk("t4_grant_after_wpop", ch_ready_o, 2'b01);
        step(); ch_valid_i = '0;
        drain();
        // write response stalled by its owner ch1 while ch0 is queued behind
        auto_r = 0; auto_w = 0; ch_valid_i = 2'b10;
        @(negedge clk); chk("t5_g1", ch_ready_o, 2'b10);
        step(); ch_valid_i = '0; step(); ch_valid_i = 2'b01;
        @(negedge clk); chk("t5_g0", ch_ready_o, 2'b01);
        step(); ch_valid_i = '0; auto_r = 1; step(); step(); step(); auto_r = 0;
        ch_w_ready_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            w_dp_valid_i = 1;
            @(negedge clk); chk("t5_stall_rdy", w_dp_ready_o, 1'b0); chk("t5_stall_v", ch_w_valid_o, 2'b10);
            step();
        end
        ch_w_ready_i = 2'b11; w_dp_valid_i = 1; auto_w = 1;
        @(negedge clk); chk("t5_pop1", ch_w_valid_o, 2'b10);
        step();
        @(negedge clk); chk("t5_pop0", ch_w_valid_o, 2'b01);
        drain();
        // asynchronous reset while a burst is mid-issue
        aw_ready_i = 0; ch_valid_i = 2'b01;
        step(); ch_valid_i = 2'b11;
        #2 rst_i = 1;
        #1 chk("t6_valids", {w_dp_valid_o, r_dp_valid_o, aw_valid_o, ar_valid_o}, 4'h0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_rdy_gate", ch_ready_o, 2'b00);
        step(); step();
        rst_i = 0; aw_ready_i = 1; ch_valid_i = '0;
        @(negedge clk); chk("t6_wrdy", w_dp_ready_o, 1'b0); chk("t6_rrdy", r_dp_ready_o, 1'b0);
        step();
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
